temp_f_bcd_formatter: RTL and testbench
=======================================

Name: temp_f_bcd_formatter

Overview:
- Upstream neighbour of the VGA display controller. Takes one signed integer Celsius sample per valid/ready handshake and converts it to Fahrenheit.
- Clamps the Fahrenheit result to the displayable range and converts it to packed BCD using a sequential restoring divider followed by a sequential double-dabble.
- Holds the 10-bit TEMP_F word stable between updates, which the display consumes as {hundreds[1:0], tens[3:0], ones[3:0]}.
- Constant latency, one conversion in flight at a time.

Parameters:
- W_IN, 8, width of signed Celsius input; legal range 6..12.
- F_MAX, 399, upper clamp in °F; must be ≤ 399 so the hundreds digit fits 2 bits.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- TEMP_C  in  W_IN  signed two's-complement Celsius sample.
- IN_VALID  in  1  TEMP_C valid.
- IN_READY  out  1  block can accept a sample; high only in IDLE.
- TEMP_F  out  10  packed BCD °F {h[1:0], t[3:0], o[3:0]}; held until next update.
- OUT_VALID  out  1  one-cycle pulse when TEMP_F/flags update.
- UNDER_RANGE  out  1  last result clamped to 0.
- OVER_RANGE  out  1  last result clamped to F_MAX.

Behaviour:
- Reset values: TEMP_F = 0, OUT_VALID = 0, UNDER_RANGE = 0, OVER_RANGE = 0, state = IDLE, IN_READY = 1 in the cycle after reset deasserts. RESET mid-conversion discards the sample; no OUT_VALID is produced for it.
- Accept occurs at an edge where IN_VALID && IN_READY. IN_VALID in any non-IDLE state is ignored and not queued.
- Arithmetic:
  - N = 9*TEMP_C + 160, signed, width W_IN+5, computed at accept with shift-add only.
  - If N < 0: quotient forced to 0 and UNDER_RANGE set; the division cycles still run.
  - Else Q = floor(N/5) by restoring division, one quotient bit per cycle, D = W_IN+5 cycles.
- Clamp: if Q > F_MAX, Q = F_MAX and OVER_RANGE is set. Result R is a 9-bit unsigned value.
- BCD: double-dabble on R, 9 shift cycles. Add 3 to any digit ≥ 5 before each shift.
- FSM: IDLE → DIV (D cycles) → CLAMP (1) → BCD (9) → UPDATE (1) → IDLE.
  - UPDATE registers TEMP_F, UNDER_RANGE and OVER_RANGE.
  - OUT_VALID is high for exactly the cycle after UPDATE.
- Latency: accept at edge k gives new TEMP_F and OUT_VALID visible from edge k+L, where L = W_IN+16 (24 at default). This is fixed, including the negative/clamped paths.
- Throughput: with IN_VALID held high, consecutive accepts are L+1 edges apart. IN_READY is low from edge k through edge k+L-1.
- Flags and TEMP_F change only at UPDATE. Flags are mutually exclusive and refer to the last sample only.
- The hundreds digit is internally 4 bits. Only bits [1:0] are output; the clamp guarantees the upper bits are 0.

Decomposition:
- Shared package (temp_pkg):
  - State encoding.
  - Constants: F_OFFSET_X5 = 160, BCD_W = 10, BIN_W = 9, F_MAX_LIMIT = 399.
  - Packed-BCD field positions (H_LSB = 8, T_LSB = 4, O_LSB = 0), reused by the display side.
- One natural sub-module: bin2bcd_seq.
  - Ports: start/busy/done handshake, 9-bit binary in, 12-bit BCD out.
  - Fixed 9-cycle operation.
- The top holds the divider, clamp and FSM.

Test Plan:
- Reset, then TEMP_C = 25 with IN_VALID one cycle → OUT_VALID at accept+24, TEMP_F = 10'b00_0111_0111 (77), both flags 0.
- TEMP_C = 100 → TEMP_F = 10'b10_0001_0010 (212). TEMP_C = 0 → 0x032 (32). TEMP_C = -17 → 0x001 (floor of 7/5).
- TEMP_C = -40 → TEMP_F = 0, UNDER_RANGE = 1, latency still 24. TEMP_C = 127 → 0x260, flags 0.
- With W_IN = 10, TEMP_C = 300 → TEMP_F = 10'b11_1001_1001 (399), OVER_RANGE = 1, latency 26.
- IN_VALID held high with changing TEMP_C → accepts spaced 25 edges apart, intermediate samples ignored, TEMP_F stable between pulses.
- Assert RESET 10 cycles after accepting 25 → no OUT_VALID, TEMP_F = 0, IN_READY = 1. Next sample 0 → 0x032 at accept+24.

Source files
------------

// File: rtl/temp_pkg.sv
// Shared constants for the temperature formatter and the display side that
// unpacks its packed-BCD word.
package temp_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DIV    = 3'd1;
    localparam logic [2:0] S_CLAMP  = 3'd2;
    localparam logic [2:0] S_BCD    = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam int F_OFFSET_X5 = 160;
    localparam int BCD_W       = 10;
    localparam int BIN_W       = 9;
    localparam int F_MAX_LIMIT = 399;

    // Field positions inside the packed TEMP_F word.
    localparam int H_LSB = 8;
    localparam int T_LSB = 4;
    localparam int O_LSB = 0;

    typedef struct packed {
        logic under;
        logic over;
    } range_flags_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: loads on start, then one adjust-and-shift per
// cycle for BIN_W cycles. done is high during the final shift cycle.
module bin2bcd_seq
    import temp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd
);

    logic [BIN_W-1:0] bin_sr;
    logic [3:0]       cnt;
    logic [11:0]      adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign done = busy && (cnt == 4'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= 4'd0;
            bin_sr <= '0;
            bcd    <= '0;
        end else if (busy) begin
            {bcd, bin_sr} <= {adj, bin_sr} << 1;
            cnt           <= cnt - 4'd1;
            if (cnt == 4'd1) busy <= 1'b0;
        end else if (start) begin
            bin_sr <= bin;
            bcd    <= '0;
            cnt    <= 4'(BIN_W);
            busy   <= 1'b1;
        end
    end

endmodule

// File: rtl/temp_f_bcd_formatter.sv
// Celsius sample -> clamped Fahrenheit packed BCD, fixed latency W_IN+16,
// one conversion in flight. Holds the divider, clamp and control FSM.
module temp_f_bcd_formatter
    import temp_pkg::*;
#(
    parameter int W_IN  = 8,
    parameter int F_MAX = 399
)
(
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic signed [W_IN-1:0] TEMP_C,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    output logic [BCD_W-1:0]       TEMP_F,
    output logic                   OUT_VALID,
    output logic                   UNDER_RANGE,
    output logic                   OVER_RANGE,
    output logic [2:0]             fsm_state
);

    localparam int NW = W_IN + 5;
    localparam int CW = $clog2(NW + 1);

    logic [2:0]           state;
    logic [NW-1:0]        quo;
    logic [3:0]           rem;
    logic [4:0]           trial;
    logic                 q_bit;
    logic [CW-1:0]        div_cnt;
    logic                 neg;
    range_flags_t         flags_pend;
    range_flags_t         r_flags;
    logic signed [NW-1:0] n_val;
    logic [BIN_W-1:0]     r_val;
    logic                 bcd_start;
    logic                 bcd_busy;
    logic                 bcd_done;
    logic [11:0]          bcd_word;
    logic                 unused_hund_hi;

    // Handshake: a sample is taken on any rising edge with IN_VALID && IN_READY;
    // IN_READY is high only in IDLE and IN_VALID elsewhere is dropped, not queued.
    assign IN_READY  = (state == S_IDLE);
    assign fsm_state = state;

    // 9*C + 160 by shift-add; the quotient by 5 is the Fahrenheit value.
    assign n_val = (NW'(TEMP_C) <<< 3) + NW'(TEMP_C) + NW'(F_OFFSET_X5);

    assign trial = {rem, quo[NW-1]};
    assign q_bit = (trial >= 5'd5);

    always_comb begin
        r_flags = '0;
        r_val   = quo[BIN_W-1:0];
        if (neg) begin
            r_val         = '0;
            r_flags.under = 1'b1;
        end else if (quo > NW'(F_MAX)) begin
            r_val        = BIN_W'(F_MAX);
            r_flags.over = 1'b1;
        end
    end

    assign bcd_start      = (state == S_CLAMP) && !bcd_busy;
    assign unused_hund_hi = |bcd_word[11:10];

    bin2bcd_seq u_bin2bcd (
        .clk   (CLOCK_50),
        .reset (RESET),
        .start (bcd_start),
        .bin   (r_val),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd   (bcd_word)
    );

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state       <= S_IDLE;
            quo         <= '0;
            rem         <= '0;
            div_cnt     <= '0;
            neg         <= 1'b0;
            flags_pend  <= '0;
            TEMP_F      <= '0;
            OUT_VALID   <= 1'b0;
            UNDER_RANGE <= 1'b0;
            OVER_RANGE  <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        neg     <= n_val[NW-1];
                        quo     <= n_val[NW-1] ? '0 : n_val;
                        rem     <= '0;
                        div_cnt <= CW'(NW);
                        state   <= S_DIV;
                    end
                end
                S_DIV: begin
                    // Restoring step: quotient bits shift in where dividend bits leave.
                    rem     <= q_bit ? 4'(trial - 5'd5) : trial[3:0];
                    quo     <= {quo[NW-2:0], q_bit};
                    div_cnt <= div_cnt - 1'b1;
                    if (div_cnt == CW'(1)) state <= S_CLAMP;
                end
                S_CLAMP: begin
                    flags_pend <= r_flags;
                    state      <= S_BCD;
                end
                S_BCD: begin
                    if (bcd_done) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    TEMP_F      <= {bcd_word[H_LSB +: 2], bcd_word[T_LSB +: 4], bcd_word[O_LSB +: 4]};
                    UNDER_RANGE <= flags_pend.under;
                    OVER_RANGE  <= flags_pend.over;
                    OUT_VALID   <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_f_bcd_formatter.sv
// Bench for temp_f_bcd_formatter: a default instance (W_IN=8) and a wide one
// (W_IN=10) for the over-range path, checked against an arithmetic model.
module tb_temp_f_bcd_formatter;

    logic CLOCK_50 = 1'b0;
    logic RESET;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic signed [7:0] tc_a;
    logic              valid_a, ready_a, ov_a, ur_a, or_a;
    logic [9:0]        tf_a;
    logic [2:0]        st_a;

    logic signed [9:0] tc_b;
    logic              valid_b, ready_b, ov_b, ur_b, or_b;
    logic [9:0]        tf_b;
    logic [2:0]        st_b;

    temp_f_bcd_formatter #(.W_IN(8), .F_MAX(399)) dut_a (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .TEMP_C(tc_a), .IN_VALID(valid_a),
        .IN_READY(ready_a), .TEMP_F(tf_a), .OUT_VALID(ov_a),
        .UNDER_RANGE(ur_a), .OVER_RANGE(or_a), .fsm_state(st_a)
    );

    temp_f_bcd_formatter #(.W_IN(10), .F_MAX(399)) dut_b (
        .CLOCK_50(CLOCK_50), .RESET(RESET), .TEMP_C(tc_b), .IN_VALID(valid_b),
        .IN_READY(ready_b), .TEMP_F(tf_b), .OUT_VALID(ov_b),
        .UNDER_RANGE(ur_b), .OVER_RANGE(or_b), .fsm_state(st_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [11:0] exp_q[$];
    int          accept_cyc[$];
    int          dir_a[6] = '{25, 100, 0, -17, -40, 127};
    int          dir_b[5] = '{300, -100, 511, -512, 0};

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {under, over, packed BCD} from plain integer arithmetic.
    function automatic logic [11:0] ref_model(input int tc, input int f_max);
        int   n, r;
        logic u, o;
        n = 9 * tc + 160;
        u = 1'b0;
        o = 1'b0;
        if (n < 0) begin
            r = 0;
            u = 1'b1;
        end else begin
            r = n / 5;
            if (r > f_max) begin
                r = f_max;
                o = 1'b1;
            end
        end
        return {u, o, 2'(r / 100), 4'((r / 10) % 10), 4'(r % 10)};
    endfunction

    function automatic logic get_ready(input int which);
        return (which != 0) ? ready_b : ready_a;
    endfunction

    function automatic logic get_ov(input int which);
        return (which != 0) ? ov_b : ov_a;
    endfunction

    function automatic logic [9:0] get_tf(input int which);
        return (which != 0) ? tf_b : tf_a;
    endfunction

    function automatic logic [1:0] get_flags(input int which);
        return (which != 0) ? {ur_b, or_b} : {ur_a, or_a};
    endfunction

    task automatic drive(input int which, input int tc, input logic v);
        if (which == 0) begin
            tc_a    = 8'(tc);
            valid_a = v;
        end else begin
            tc_b    = 10'(tc);
            valid_b = v;
        end
    endtask

    task automatic send(input int which, input int tc);
        int          lat, wait_n, lat_exp;
        logic [11:0] e;
        lat_exp = (which != 0) ? 26 : 24;
        e       = ref_model(tc, 399);
        wait_n  = 0;
        while (!get_ready(which) && wait_n < 200) begin
            @(posedge CLOCK_50); #1;
            wait_n++;
        end
        check_eq($sformatf("ready_wait dut%0d", which), int'(get_ready(which)), 1);
        @(negedge CLOCK_50);
        drive(which, tc, 1'b1);
        @(posedge CLOCK_50); #1;
        drive(which, tc, 1'b0);
        check_eq($sformatf("ready_busy dut%0d tc=%0d", which, tc), int'(get_ready(which)), 0);
        lat = 0;
        while (!get_ov(which) && lat < lat_exp + 10) begin
            @(posedge CLOCK_50); #1;
            lat++;
        end
        check_eq($sformatf("latency dut%0d tc=%0d", which, tc), lat, lat_exp);
        check_eq($sformatf("temp_f dut%0d tc=%0d", which, tc), int'(get_tf(which)), int'(e[9:0]));
        check_eq($sformatf("flags dut%0d tc=%0d", which, tc), int'(get_flags(which)), int'(e[11:10]));
        @(posedge CLOCK_50); #1;
        check_eq($sformatf("ov_pulse dut%0d tc=%0d", which, tc), int'(get_ov(which)), 0);
        check_eq($sformatf("temp_f_hold dut%0d tc=%0d", which, tc), int'(get_tf(which)), int'(e[9:0]));
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          tc, pulses;
        logic [11:0] e;
        logic [9:0]  held;

        // Clock/reset
        RESET = 1'b1;
        drive(0, 0, 1'b0);
        drive(1, 0, 1'b0);
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50) RESET = 1'b0;
        @(posedge CLOCK_50); #1;
        check_eq("reset temp_f_a", int'(tf_a), 0);
        check_eq("reset out_valid_a", int'(ov_a), 0);
        check_eq("reset flags_a", int'({ur_a, or_a}), 0);
        check_eq("reset in_ready_a", int'(ready_a), 1);
        check_eq("reset temp_f_b", int'(tf_b), 0);
        check_eq("reset in_ready_b", int'(ready_b), 1);

        // Directed values, both widths
        foreach (dir_a[i]) send(0, dir_a[i]);
        foreach (dir_b[i]) send(1, dir_b[i]);

        // Random samples over the full input range
        repeat (12) send(0, int'($urandom_range(255)) - 128);
        repeat (8)  send(1, int'($urandom_range(1023)) - 512);

        // IN_VALID held high with TEMP_C changing every cycle
        held   = tf_a;
        pulses = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge CLOCK_50);
            tc = int'($urandom_range(255)) - 128;
            drive(0, tc, 1'b1);
            if (ready_a) begin
                exp_q.push_back(ref_model(tc, 399));
                accept_cyc.push_back(cyc);
            end
            @(posedge CLOCK_50); #1;
            if (ov_a) begin
                pulses++;
                check_eq("stream pulse_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("stream temp_f", int'(tf_a), int'(e[9:0]));
                    check_eq("stream flags", int'({ur_a, or_a}), int'(e[11:10]));
                end
                held = tf_a;
            end else begin
                check_eq("stream temp_f_stable", int'(tf_a), int'(held));
            end
        end
        @(negedge CLOCK_50);
        drive(0, 0, 1'b0);
        for (int d = 0; d < 40 && exp_q.size() > 0; d++) begin
            @(posedge CLOCK_50); #1;
            if (ov_a) begin
                pulses++;
                e = exp_q.pop_front();
                check_eq("drain temp_f", int'(tf_a), int'(e[9:0]));
                check_eq("drain flags", int'({ur_a, or_a}), int'(e[11:10]));
            end
        end
        check_eq("stream all_results", exp_q.size(), 0);
        check_eq("stream accept_count", accept_cyc.size(), 4);
        for (int i = 1; i < accept_cyc.size(); i++) begin
            check_eq($sformatf("stream spacing %0d", i), accept_cyc[i] - accept_cyc[i-1], 25);
        end

        // Reset in the middle of a conversion discards the sample
        @(negedge CLOCK_50);
        drive(0, 25, 1'b1);
        @(posedge CLOCK_50); #1;
        drive(0, 25, 1'b0);
        repeat (9) @(posedge CLOCK_50);
        @(negedge CLOCK_50) RESET = 1'b1;
        @(posedge CLOCK_50); #1;
        @(negedge CLOCK_50) RESET = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(posedge CLOCK_50); #1;
            if (ov_a) pulses++;
        end
        check_eq("midreset no_out_valid", pulses, 0);
        check_eq("midreset temp_f", int'(tf_a), 0);
        check_eq("midreset in_ready", int'(ready_a), 1);
        check_eq("midreset flags", int'({ur_a, or_a}), 0);
        send(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
